// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - byte-serial instruction fetch from program ROM with valid/ready hand-off
// Four ROM byte reads per instruction; returns are tracked by a ROM_LATENCY-deep {valid, k} pipe.
module instruction_fetch #(
  parameter int ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        is_powered_on,
  input  logic [15:0] program_counter,
  input  logic        flush,
  output logic        pc_advance,
  output logic        rom_rd,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] fetch_pc
);

  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic [15:0]            base_q, base_d;
  logic [31:0]            instr_q, instr_d;
  logic [ROM_LATENCY-1:0] ret_v_q;
  logic [1:0]             ret_k_q [ROM_LATENCY];
  logic [15:0]            addr_word;
  logic                   ret_v;
  logic [1:0]             ret_k;
  logic                   capture;

  assign ret_v     = ret_v_q[ROM_LATENCY-1];
  assign ret_k     = ret_k_q[ROM_LATENCY-1];
  assign capture   = ret_v & ~flush;
  // At k=0 the base is not yet latched, so the live program counter addresses the first byte.
  assign addr_word = (k_q == 2'd0) ? program_counter : base_q;

  assign instr_valid = is_powered_on & (state_q == S_HOLD);
  assign pc_advance  = instr_valid & instr_ready & ~flush;
  assign rom_rd      = is_powered_on & (state_q == S_FETCH) & ~flush;
  assign rom_addr    = rom_rd ? {addr_word[13:0], k_q} : 16'd0;
  assign instr       = instr_q;
  assign fetch_pc    = base_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    instr_d = instr_q;
    if (capture) begin
      instr_d[{ret_k, 3'b000} +: 8] = rom_data;
    end
    case (state_q)
      S_FETCH: begin
        if (rom_rd) begin
          if (k_q == 2'd0) begin
            base_d = program_counter;
          end
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (capture && ret_k == 2'd3) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pc_advance) begin
          state_d = S_FETCH;
          k_d     = 2'd0;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (flush) begin
      state_d = S_FETCH;
      k_d     = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!is_powered_on) begin
      state_q <= S_FETCH;
      k_q     <= 2'd0;
      base_q  <= 16'd0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      instr_q <= instr_d;
    end
  end

  // Flush empties the return pipe so responses to abandoned reads are never captured.
  always_ff @(posedge clk) begin
    if (!is_powered_on || flush) begin
      ret_v_q <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        ret_k_q[i] <= 2'd0;
      end
    end else begin
      ret_v_q[0] <= rom_rd;
      ret_k_q[0] <= k_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        ret_v_q[i] <= ret_v_q[i-1];
        ret_k_q[i] <= ret_k_q[i-1];
      end
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Reads the 32-bit instruction at the current program counter from the byte-wide program ROM and presents it to the decoder over a valid/ready handshake. It is the consumer of the program counter that PC_NEXT produces. Acceptance of an instruction pulses `pc_advance`, which tells PC_NEXT to step. `flush` discards an in-progress fetch on jumps, and fetch restarts from whatever PC is then present.

## Interface
- `ROM_LATENCY`, default 1: cycles from a ROM read issue to valid `rom_data`. Legal range 1..4.

- `clk`  in  1  rising-edge clock
- `is_powered_on`  in  1  synchronous active-low reset; 0 = reset
- `program_counter`  in  16  word address of the next instruction, from PC_NEXT
- `flush`  in  1  abandon the current fetch and restart from `program_counter`
- `pc_advance`  out  1  one-cycle pulse; PC_NEXT increments on this edge
- `rom_rd`  out  1  ROM read strobe, one byte per cycle
- `rom_addr`  out  16  ROM byte address
- `rom_data`  in  8  ROM read data, valid `ROM_LATENCY` cycles after `rom_rd`
- `instr`  out  32  assembled instruction, little-endian
- `instr_valid`  out  1  `instr`/`fetch_pc` are valid
- `instr_ready`  in  1  decoder accepts `instr` this cycle
- `fetch_pc`  out  16  `program_counter` value the held `instr` was fetched from

## Operation
- Reset: one clock, synchronous and active-low. Clock is `clk`; reset is `is_powered_on`, synchronous, active-low.
- While `is_powered_on`=0 at a clock edge:
  - state goes to FETCH, with byte index 0 and return tracking cleared.
  - `instr`=0, `instr_valid`=0, `fetch_pc`=0, `rom_rd`=0, `rom_addr`=0, `pc_advance`=0.
- FETCH: on byte index k=0 the block latches `program_counter` as base P.
  - Each FETCH cycle drives `rom_rd`=1 and `rom_addr`=(P*4+k) mod 2^16.
  - k runs 0,1,2,3 on consecutive cycles; after k=3 the state goes to DRAIN.
  - The address wraps silently: P=0xFFFF gives byte addresses 0xFFFC..0xFFFF; P≥0x4000 truncates.
- Return tracking: a `ROM_LATENCY`-deep shift register of {valid, k} follows each issued read.
  - When a valid entry emerges, `rom_data` is written into `instr[8k+7:8k]`.
- DRAIN: `rom_rd`=0. The state leaves after the byte with k=3 is captured and goes to HOLD.
  - For small `ROM_LATENCY`, returns overlap with FETCH; DRAIN still lasts until byte 3 lands.
- HOLD: `instr_valid`=1, and `instr` and `fetch_pc`=P are stable.
  - `pc_advance` = `instr_valid` & `instr_ready` & ~`flush`, combinational.
  - On handshake: `instr_valid` clears and the state goes to FETCH with k=0. The next fetch uses the already-incremented `program_counter`.
- `flush`=1 in any state, with priority over the handshake:
  - return tracking is cleared, so ROM responses already in flight are ignored;
  - `instr_valid` clears and `pc_advance` stays 0;
  - state goes to FETCH with k=0 and latches the new `program_counter` next cycle.
- `flush` held for several cycles: the block stays in FETCH with k=0 and `rom_rd`=0, and issues nothing until `flush` drops.
- `instr_ready` outside HOLD is ignored.
- `program_counter` must be held stable by its producer except on `pc_advance` or jump+`flush`. The block samples it only at k=0.

## Timing
- FETCH k=0 at cycle t:
  - reads issue in cycles t..t+3;
  - byte 3 is captured at the end of cycle t+3+L;
  - `instr_valid`=1 from cycle t+4+L (L=`ROM_LATENCY`).
- With `instr_ready` tied high, an instruction issues every 5+L cycles:
  - handshake in cycle t+4+L;
  - next k=0 in cycle t+5+L.
- `pc_advance` is high for exactly one cycle per accepted instruction and never while `is_powered_on`=0.
- Reset release: the first FETCH k=0 occurs in the first cycle with `is_powered_on`=1.
- Reset asserted mid-fetch: all state is lost at that edge, and no stale byte is captured after release.

## Test plan
- **Reset then fetch, L=1.**
  - Stimulus: ROM bytes 0..3 = 0x11,0x22,0x33,0x44; PC=0; ready=1.
  - Required: `rom_addr` 0,1,2,3 in cycles 0–3; `instr`=0x44332211 and `fetch_pc`=0 with valid in cycle 5; `pc_advance` pulses in cycle 5.
- **Back-pressure.**
  - Stimulus: ready=0 for 10 cycles after valid.
  - Required: `instr` and `fetch_pc` held constant, `pc_advance`=0, `rom_rd`=0 throughout; with ready=1, one `pc_advance` and the next fetch from PC=1 at `rom_addr`=4.
- **Flush mid-fetch, L=3.**
  - Stimulus: flush at k=2 with PC changed to 0x0010.
  - Required: the next `rom_addr` sequence is 0x40..0x43; no byte from the old fetch appears in `instr`; `fetch_pc`=0x0010.
- **Flush and ready in the same HOLD cycle.**
  - Required: `pc_advance`=0 and `instr_valid` drops.
- **Wrap-around.**
  - Stimulus: PC=0xFFFF.
  - Required: `rom_addr` 0xFFFC..0xFFFF; `fetch_pc`=0xFFFF.
- **Reset mid-DRAIN, L=4.**
  - Stimulus: `is_powered_on`=0 for 1 cycle during DRAIN.
  - Required: all outputs 0 next cycle; after release, a clean fetch from the current PC with no stale bytes.
